mdio_master: RTL and testbench



---
 rtl/mdio_master.sv | 232 +++++++++++++++++++++++
 tb/tb_mdio_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO management-frame initiator (one register read or write per command).
// Latency: slot 0 starts the cycle after acceptance; the response pulses N*MDC_DIV+1 cycles after acceptance (N = 64, or 32 without preamble).
// Backpressure: cmd_ready is low for the whole frame; a new command can be taken in the completion (rsp_valid) cycle.
//
// Ports:
//   clk_200m, rst_200m           sole clock; asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake; cmd_write (1 = write, OP 01; 0 = read, OP 10),
//                                cmd_phyad, cmd_regad, cmd_wdata latched on acceptance
//   cmd_nopre                    only with MDIO_MASTER_PRE_SUPPRESS_EN defined: 1 skips the 32-slot preamble
//   rsp_valid                    one-cycle completion pulse
//   rsp_rdata, rsp_err           read data (0 after a write) and missing-turnaround flag, held until the next response
//   busy                         inverse of cmd_ready
//   mdc, mdio_out, mdio_oen      management clock, serial data, active-low pad output enable (1 = released)
//   mdio_in                      pad input, asynchronous to clk_200m
//
// Optional feature macro: MDIO_MASTER_PRE_SUPPRESS_EN (adds cmd_nopre). MDC_DIV must be even and >= 4.

module mdio_master #(
    parameter int MDC_DIV = 40
) (
    input  logic        clk_200m,
    input  logic        rst_200m,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
`ifdef MDIO_MASTER_PRE_SUPPRESS_EN
    input  logic        cmd_nopre,
`endif
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oen,
    input  logic        mdio_in
);

    localparam int DIV_W = (MDC_DIV > 2) ? $clog2(MDC_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MDC_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MDC_DIV / 2);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_ST,
        S_OP,
        S_PHY,
        S_REG,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [4:0]       bit_cnt, bit_nx;
    logic [DIV_W-1:0] div_cnt, div_nx;
    logic             wr_q, wr_nx;
    logic [31:0]      tx_sr, tx_nx;
    logic [15:0]      rd_sr, rd_nx;
    logic             ta_err, ta_err_nx;
    logic             mdc_nx, out_nx, oen_nx;
    logic             rsp_valid_nx, err_nx;
    logic [15:0]      rdata_nx;
    logic             slot_end;
    logic             skip_pre;
    logic             mdio_s1, mdio_s2;

`ifdef MDIO_MASTER_PRE_SUPPRESS_EN
    // The preamble choice only matters for the first slot, so it is consumed at acceptance.
    assign skip_pre = cmd_nopre;
`else
    assign skip_pre = 1'b0;
`endif

    // DONE is the completion cycle; the block is already free to take the next command there,
    // which is what lets back-to-back frames start with only a one-clock gap.
    assign cmd_ready = (state == S_IDLE) || (state == S_DONE);
    assign busy      = ~cmd_ready;
    assign slot_end  = (div_cnt == DIV_LAST);

    // Index of the final slot of each field.
    function automatic logic [4:0] last_bit(input state_t s);
        case (s)
            S_PRE:              last_bit = 5'd31;
            S_ST, S_OP, S_TA:   last_bit = 5'd1;
            S_PHY, S_REG:       last_bit = 5'd4;
            S_DATA:             last_bit = 5'd15;
            default:            last_bit = 5'd0;
        endcase
    endfunction

    function automatic state_t field_after(input state_t s);
        case (s)
            S_PRE:   field_after = S_ST;
            S_ST:    field_after = S_OP;
            S_OP:    field_after = S_PHY;
            S_PHY:   field_after = S_REG;
            S_REG:   field_after = S_TA;
            S_TA:    field_after = S_DATA;
            S_DATA:  field_after = S_DONE;
            default: field_after = S_IDLE;
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous pad input; idle bus level is 1.
    always_ff @(posedge clk_200m or posedge rst_200m) begin
        if (rst_200m) begin
            mdio_s1 <= 1'b1;
            mdio_s2 <= 1'b1;
        end else begin
            mdio_s1 <= mdio_in;
            mdio_s2 <= mdio_s1;
        end
    end

    always_ff @(posedge clk_200m or posedge rst_200m) begin
        if (rst_200m) begin
            state     <= S_IDLE;
            bit_cnt   <= 5'd0;
            div_cnt   <= '0;
            wr_q      <= 1'b0;
            tx_sr     <= 32'hFFFF_FFFF;
            rd_sr     <= 16'h0000;
            ta_err    <= 1'b0;
            mdc       <= 1'b0;
            mdio_out  <= 1'b1;
            mdio_oen  <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'h0000;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_nx;
            div_cnt   <= div_nx;
            wr_q      <= wr_nx;
            tx_sr     <= tx_nx;
            rd_sr     <= rd_nx;
            ta_err    <= ta_err_nx;
            mdc       <= mdc_nx;
            mdio_out  <= out_nx;
            mdio_oen  <= oen_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_rdata <= rdata_nx;
            rsp_err   <= err_nx;
        end
    end

    // All pin outputs are registered: values for a slot are computed on the clock that ends
    // the previous slot (or accepts the command), so they change only on a slot's first clock.
    always_comb begin
        state_nx     = state;
        bit_nx       = bit_cnt;
        div_nx       = div_cnt;
        wr_nx        = wr_q;
        tx_nx        = tx_sr;
        rd_nx        = rd_sr;
        ta_err_nx    = ta_err;
        mdc_nx       = mdc;
        out_nx       = mdio_out;
        oen_nx       = mdio_oen;
        rsp_valid_nx = 1'b0;
        rdata_nx     = rsp_rdata;
        err_nx       = rsp_err;

        case (state)
            S_IDLE, S_DONE: begin
                state_nx = S_IDLE;
                if (cmd_valid && cmd_ready) begin
                    state_nx = skip_pre ? S_ST : S_PRE;
                    bit_nx   = 5'd0;
                    div_nx   = '0;
                    mdc_nx   = 1'b0;
                    wr_nx    = cmd_write;
                    // Everything after the preamble as one MSB-first word. For reads the
                    // TA/DATA part is all ones, matching the released-bus output level.
                    tx_nx    = cmd_write ? {2'b01, 2'b01, cmd_phyad, cmd_regad, 2'b10, cmd_wdata}
                                         : {2'b01, 2'b10, cmd_phyad, cmd_regad, 18'h3FFFF};
                    out_nx   = ~skip_pre;
                    oen_nx   = 1'b0;
                end
            end

            default: begin
                if (!slot_end) begin
                    div_nx = div_cnt + 1'b1;
                    mdc_nx = (div_nx >= DIV_HALF);
                end else begin
                    div_nx = '0;
                    mdc_nx = 1'b0;

                    // The preamble is not part of tx_sr, so only shift once past it.
                    if (state != S_PRE) begin
                        tx_nx = {tx_sr[30:0], 1'b1};
                    end

                    if (!wr_q) begin
                        if ((state == S_TA) && (bit_cnt == 5'd1)) begin
                            ta_err_nx = mdio_s2;
                        end
                        if (state == S_DATA) begin
                            rd_nx = {rd_sr[14:0], mdio_s2};
                        end
                    end

                    if (bit_cnt == last_bit(state)) begin
                        state_nx = field_after(state);
                        bit_nx   = 5'd0;
                    end else begin
                        bit_nx   = bit_cnt + 5'd1;
                    end

                    if (state_nx == S_DONE) begin
                        rsp_valid_nx = 1'b1;
                        rdata_nx     = wr_q ? 16'h0000 : rd_nx;
                        err_nx       = ~wr_q & ta_err_nx;
                        out_nx       = 1'b1;
                        oen_nx       = 1'b1;
                    end else begin
                        out_nx = (state_nx == S_PRE) ? 1'b1 : tx_nx[31];
                        // Reads hand the bus to the responder from the first TA slot on.
                        oen_nx = ~wr_q & ((state_nx == S_TA) || (state_nx == S_DATA));
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed bench for mdio_master with MDC_DIV = 4.
// Latency: checks the response cycle against acceptance (T+257, or T+129 without preamble).
// Backpressure: exercises back-to-back commands with cmd_valid held high.

`timescale 1ns/1ps

module tb_mdio_master;

    localparam int DIV = 4;

    logic        clk_200m = 1'b0;
    logic        rst_200m;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phyad;
    logic [4:0]  cmd_regad;
    logic [15:0] cmd_wdata;
`ifdef MDIO_MASTER_PRE_SUPPRESS_EN
    logic        cmd_nopre;
`endif
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        mdc;
    logic        mdio_out;
    logic        mdio_oen;
    logic        mdio_in;

    always #5 clk_200m = ~clk_200m;

    mdio_master #(.MDC_DIV(DIV)) dut (
        .clk_200m  (clk_200m),
        .rst_200m  (rst_200m),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_phyad (cmd_phyad),
        .cmd_regad (cmd_regad),
        .cmd_wdata (cmd_wdata),
`ifdef MDIO_MASTER_PRE_SUPPRESS_EN
        .cmd_nopre (cmd_nopre),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mdc       (mdc),
        .mdio_out  (mdio_out),
        .mdio_oen  (mdio_oen),
        .mdio_in   (mdio_in)
    );

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          n_rise;
    int          rsp_cnt;
    int          rsp_cyc;
    int          t_acc;
    int          hi_run;
    int          bad_hi;
    int          n_idle;
    int          rsp_before;
    logic [63:0] rx_bits;
    logic [63:0] rx_oen;
    logic [63:0] resp_vec;
    logic        resp_on;
    logic        mdc_d;
    logic        mdc_at_rsp;
    logic [15:0] last_rdata;
    logic        last_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe on the falling edge, act as the bus responder, log events.
    task automatic tick();
        @(negedge clk_200m);
        cyc++;
        if (mdc && !mdc_d) begin
            rx_bits = {rx_bits[62:0], mdio_out};
            rx_oen  = {rx_oen[62:0], mdio_oen};
            // Drive the next slot's value just after this rising edge.
            if (resp_on && n_rise < 63) mdio_in = resp_vec[62 - n_rise];
            n_rise++;
        end
        if (mdc) begin
            hi_run++;
        end else begin
            if (hi_run != 0 && hi_run != DIV / 2) bad_hi++;
            hi_run = 0;
        end
        mdc_d = mdc;
        if (!busy) n_idle++;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_cyc    = cyc;
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
            mdc_at_rsp = mdc;
        end
    endtask

    task automatic frame_start();
        rx_bits = '0;
        rx_oen  = '0;
        n_rise  = 0;
    endtask

    // Presents a command and returns one clock after the handshake; t_acc is the handshake cycle.
    task automatic send(input string tag, input logic wr, input logic [4:0] phy,
                        input logic [4:0] rad, input logic [15:0] wd);
        cmd_write = wr;
        cmd_phyad = phy;
        cmd_regad = rad;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        for (int i = 0; i < 2000 && !cmd_ready; i++) tick();
        check({tag, "_ready"}, cmd_ready, 1);
        t_acc = cyc;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int n);
        for (int i = 0; i < 2000 && rsp_cnt < n; i++) tick();
        check({tag, "_rsp_cnt"}, rsp_cnt, n);
    endtask

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; n_rise = 0; rsp_cnt = 0; rsp_cyc = 0;
        t_acc = 0; hi_run = 0; bad_hi = 0; n_idle = 0; rsp_before = 0;
        rx_bits = '0; rx_oen = '0; resp_vec = '1; resp_on = 1'b0; mdc_d = 1'b0;
        mdc_at_rsp = 1'b0; last_rdata = '0; last_err = 1'b0;
        rst_200m = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_phyad = '0; cmd_regad = '0; cmd_wdata = '0; mdio_in = 1'b1;
`ifdef MDIO_MASTER_PRE_SUPPRESS_EN
        cmd_nopre = 1'b0;
`endif

        // Reset values: {cmd_ready, busy, rsp_valid, mdc, mdio_out, mdio_oen}
        repeat (3) tick();
        check("rst_ctrl", {cmd_ready, busy, rsp_valid, mdc, mdio_out, mdio_oen}, 6'b100011);
        check("rst_rdata", rsp_rdata, 16'h0000);
        check("rst_err", rsp_err, 0);
        rst_200m = 1'b0;
        repeat (2) tick();

        // Write frame
        frame_start();
        send("wr", 1'b1, 5'h01, 5'h03, 16'hA5C3);
        wait_rsp("wr", 1);
        check("wr_latency", rsp_cyc - t_acc, 257);
        check("wr_nbits", n_rise, 64);
        check("wr_bits", rx_bits, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h03, 2'b10, 16'hA5C3});
        check("wr_oen", rx_oen, 64'h0);
        check("wr_rdata", last_rdata, 16'h0000);
        check("wr_err", last_err, 0);

        // Read frame with a responder: TA slot 2 = 0, then 16'h1234
        resp_vec = {{46{1'b1}}, 2'b10, 16'h1234};
        resp_on  = 1'b1;
        frame_start();
        send("rd", 1'b0, 5'h1F, 5'h02, 16'h0000);
        wait_rsp("rd", 2);
        resp_on = 1'b0;
        mdio_in = 1'b1;
        check("rd_latency", rsp_cyc - t_acc, 257);
        check("rd_bits", rx_bits, {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h1F, 5'h02, 18'h3FFFF});
        check("rd_oen", rx_oen, {46'h0, 18'h3FFFF});
        check("rd_rdata", last_rdata, 16'h1234);
        check("rd_err", last_err, 0);

        // Read with nobody answering: bus floats high
        frame_start();
        send("nr", 1'b0, 5'h05, 5'h01, 16'h0000);
        wait_rsp("nr", 3);
        check("nr_rdata", last_rdata, 16'hFFFF);
        check("nr_err", last_err, 1);

        // Back-to-back writes with cmd_valid held
        frame_start();
        send("b2b1", 1'b1, 5'h02, 5'h04, 16'h0001);
        n_idle = 0;
        send("b2b2", 1'b1, 5'h03, 5'h05, 16'h8000);
        check("b2b_accept_cycle", t_acc, rsp_cyc);
        check("b2b_first_rsp", rsp_cnt, 4);
        check("b2b_busy_low", n_idle, 1);
        check("b2b_mdc_gap", mdc_at_rsp, 0);
        check("b2b_rdata", last_rdata, 16'h0000);
        wait_rsp("b2b", 5);
        check("b2b_latency2", rsp_cyc - t_acc, 257);

        // Reset in the DATA phase of a read
        resp_vec = {{46{1'b1}}, 2'b10, 16'h1234};
        resp_on  = 1'b1;
        frame_start();
        send("mr", 1'b0, 5'h07, 5'h09, 16'h0000);
        for (int i = 0; i < 2000 && n_rise < 52; i++) tick();
        check("mr_in_data", mdc, 1);
        rsp_before = rsp_cnt;
        rst_200m = 1'b1;
        #1;
        check("mr_ctrl", {cmd_ready, busy, rsp_valid, mdc, mdio_out, mdio_oen}, 6'b100011);
        check("mr_rdata", rsp_rdata, 16'h0000);
        check("mr_err", rsp_err, 0);
        hi_run = 0;
        repeat (4) tick();
        rst_200m = 1'b0;
        resp_on  = 1'b0;
        mdio_in  = 1'b1;
        repeat (2) tick();
        check("mr_no_rsp", rsp_cnt, rsp_before);
        check("mr_ready", cmd_ready, 1);
        frame_start();
        send("mrw", 1'b1, 5'h11, 5'h1E, 16'h5A0F);
        wait_rsp("mrw", rsp_before + 1);
        check("mrw_latency", rsp_cyc - t_acc, 257);
        check("mrw_bits", rx_bits, {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h11, 5'h1E, 2'b10, 16'h5A0F});

`ifdef MDIO_MASTER_PRE_SUPPRESS_EN
        // Preamble suppressed: 32-slot frame starting with ST
        rsp_before = rsp_cnt;
        frame_start();
        cmd_nopre = 1'b1;
        send("np", 1'b1, 5'h0A, 5'h15, 16'hBEEF);
        cmd_nopre = 1'b0;
        wait_rsp("np", rsp_before + 1);
        check("np_latency", rsp_cyc - t_acc, 129);
        check("np_nbits", n_rise, 32);
        check("np_bits", rx_bits, {32'h0, 2'b01, 2'b01, 5'h0A, 5'h15, 2'b10, 16'hBEEF});
`endif

        check("mdc_high_width", bad_hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
